// File: rtl/mem_req_squash_tracker.sv
// mem_req_squash_tracker
//
// Request-side companion to the processor's response drop logic. Requests are
// forwarded to memory combinationally while the tracker counts in-flight
// transactions. A squash reclassifies every outstanding response as
// "to drop"; those responses are absorbed as they return so only live
// responses reach the pipeline. Memory returns responses in order, so all
// to-drop responses arrive before any live one.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   squash                  discard all outstanding responses
//   req_msg/en/rdy          processor -> tracker request (en/rdy handshake)
//   memreq_msg/en/rdy       tracker -> memory request
//   memresp_msg/en/rdy      memory -> tracker response
//   resp_msg/en/rdy         tracker -> processor response
//   live_cnt                outstanding responses that will be delivered
//   drop_cnt                outstanding responses that will be discarded

// Simulation-only protocol checker: a response must never return while
// nothing is outstanding.
module mem_req_squash_tracker_chk #(
    parameter int c_cnt_nbits = 3
) (
    input logic                   clk,
    input logic                   reset_n,
    input logic                   memresp_en,
    input logic                   memresp_rdy,
    input logic [c_cnt_nbits-1:0] live_cnt,
    input logic [c_cnt_nbits-1:0] drop_cnt
);

    // Response with no outstanding transaction is a protocol error.
    resp_without_req_a : assert property (@(posedge clk) disable iff (!reset_n)
        (memresp_en && memresp_rdy) |->
        ((live_cnt != {c_cnt_nbits{1'b0}}) || (drop_cnt != {c_cnt_nbits{1'b0}})))
        else $error("memresp_en asserted with no outstanding request");

endmodule

module mem_req_squash_tracker #(
    parameter int p_req_nbits    = 77,
    parameter int p_resp_nbits   = 47,
    parameter int p_max_inflight = 4
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                squash,
    input  logic [p_req_nbits-1:0]              req_msg,
    input  logic                                req_en,
    output logic                                req_rdy,
    output logic [p_req_nbits-1:0]              memreq_msg,
    output logic                                memreq_en,
    input  logic                                memreq_rdy,
    input  logic [p_resp_nbits-1:0]             memresp_msg,
    input  logic                                memresp_en,
    output logic                                memresp_rdy,
    output logic [p_resp_nbits-1:0]             resp_msg,
    output logic                                resp_en,
    input  logic                                resp_rdy,
    output logic [$clog2(p_max_inflight+1)-1:0] live_cnt,
    output logic [$clog2(p_max_inflight+1)-1:0] drop_cnt
);

    localparam int c_cnt_nbits = $clog2(p_max_inflight + 1);
    // One extra bit so live + drop cannot overflow before comparison.
    localparam int c_sum_nbits = c_cnt_nbits + 1;

    // PASS: nothing left to discard; DRAIN: stale responses still to absorb.
    typedef enum logic {
        ST_PASS  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    logic [c_cnt_nbits-1:0] live_cnt_r;
    logic [c_cnt_nbits-1:0] drop_cnt_r;
    logic [c_cnt_nbits-1:0] live_cnt_nxt_s;
    logic [c_cnt_nbits-1:0] drop_cnt_nxt_s;
    logic [c_sum_nbits-1:0] total_s;
    logic                   full_s;
    logic                   issue_s;
    logic                   resp_dec_s;
    state_e                 state_s;

    assign total_s = {1'b0, live_cnt_r} + {1'b0, drop_cnt_r};
    assign full_s  = (total_s == c_sum_nbits'(p_max_inflight));
    assign state_s = (drop_cnt_r != {c_cnt_nbits{1'b0}}) ? ST_DRAIN : ST_PASS;

    // Pure pass-through data paths; the tracker holds no message storage.
    assign memreq_msg = req_msg;
    assign resp_msg   = memresp_msg;
    assign live_cnt   = live_cnt_r;
    assign drop_cnt   = drop_cnt_r;

    // Issue handshake: full is computed from registered counts only, so a
    // response returning this cycle cannot open a slot combinationally.
    always_comb begin
        req_rdy = 1'b0;
        issue_s = 1'b0;
        if (reset_n) begin
            req_rdy = memreq_rdy && !full_s && !squash;
            issue_s = req_en && req_rdy;
        end else begin
            req_rdy = 1'b0;
            issue_s = 1'b0;
        end
    end

    assign memreq_en = issue_s;

    // Response handshake: forward in PASS, absorb in DRAIN or on a squash.
    always_comb begin
        memresp_rdy = 1'b0;
        resp_en     = 1'b0;
        if (!reset_n) begin
            memresp_rdy = 1'b0;
            resp_en     = 1'b0;
        end else if (squash) begin
            memresp_rdy = 1'b1;
            resp_en     = 1'b0;
        end else begin
            case (state_s)
                ST_PASS: begin
                    memresp_rdy = resp_rdy;
                    resp_en     = memresp_en;
                end
                ST_DRAIN: begin
                    memresp_rdy = 1'b1;
                    resp_en     = 1'b0;
                end
                default: begin
                    memresp_rdy = 1'b1;
                    resp_en     = 1'b0;
                end
            endcase
        end
    end

    // A response only retires a count when something is outstanding, so a
    // spurious response saturates the counters at zero instead of wrapping.
    assign resp_dec_s = memresp_en && memresp_rdy && (total_s != {c_sum_nbits{1'b0}});

    // Counter next-state: a squash folds all live entries into the drop count,
    // minus any response consumed in that same cycle.
    always_comb begin
        live_cnt_nxt_s = live_cnt_r;
        drop_cnt_nxt_s = drop_cnt_r;
        if (squash) begin
            live_cnt_nxt_s = {c_cnt_nbits{1'b0}};
            drop_cnt_nxt_s = c_cnt_nbits'(total_s - {{c_cnt_nbits{1'b0}}, resp_dec_s});
        end else begin
            case (state_s)
                ST_PASS: begin
                    live_cnt_nxt_s = live_cnt_r + c_cnt_nbits'(issue_s)
                                   - c_cnt_nbits'(resp_dec_s);
                end
                ST_DRAIN: begin
                    live_cnt_nxt_s = live_cnt_r + c_cnt_nbits'(issue_s);
                    drop_cnt_nxt_s = drop_cnt_r - c_cnt_nbits'(resp_dec_s);
                end
                default: begin
                    live_cnt_nxt_s = live_cnt_r;
                    drop_cnt_nxt_s = drop_cnt_r;
                end
            endcase
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live_cnt_r <= {c_cnt_nbits{1'b0}};
            drop_cnt_r <= {c_cnt_nbits{1'b0}};
        end else begin
            live_cnt_r <= live_cnt_nxt_s;
            drop_cnt_r <= drop_cnt_nxt_s;
        end
    end

    mem_req_squash_tracker_chk #(
        .c_cnt_nbits (c_cnt_nbits)
    ) u_chk (
        .clk         (clk),
        .reset_n     (reset_n),
        .memresp_en  (memresp_en),
        .memresp_rdy (memresp_rdy),
        .live_cnt    (live_cnt_r),
        .drop_cnt    (drop_cnt_r)
    );

endmodule

// File: tb/tb_mem_req_squash_tracker.sv
// Self-checking bench for mem_req_squash_tracker. A small in-order memory
// model holds each issued request with a live/dropped flag; a squash marks
// everything outstanding as dropped. Expected deliveries are queued when a
// response is driven and compared when the DUT strobes resp_en.
module tb_mem_req_squash_tracker;

    localparam int REQ_W  = 77;
    localparam int RESP_W = 47;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              reset_n;
    logic              squash;
    logic [REQ_W-1:0]  req_msg;
    logic              req_en;
    logic              req_rdy;
    logic [REQ_W-1:0]  memreq_msg;
    logic              memreq_en;
    logic              memreq_rdy;
    logic [RESP_W-1:0] memresp_msg;
    logic              memresp_en;
    logic              memresp_rdy;
    logic [RESP_W-1:0] resp_msg;
    logic              resp_en;
    logic              resp_rdy;
    logic [CNT_W-1:0]  live_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    typedef struct packed {
        logic              live;
        logic [RESP_W-1:0] msg;
    } ent_t;

    ent_t              mem_q[$];
    logic [RESP_W-1:0] exp_q[$];
    int                n_cmp = 0;
    int                n_err = 0;

    mem_req_squash_tracker #(
        .p_req_nbits    (REQ_W),
        .p_resp_nbits   (RESP_W),
        .p_max_inflight (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .squash      (squash),
        .req_msg     (req_msg),
        .req_en      (req_en),
        .req_rdy     (req_rdy),
        .memreq_msg  (memreq_msg),
        .memreq_en   (memreq_en),
        .memreq_rdy  (memreq_rdy),
        .memresp_msg (memresp_msg),
        .memresp_en  (memresp_en),
        .memresp_rdy (memresp_rdy),
        .resp_msg    (resp_msg),
        .resp_en     (resp_en),
        .resp_rdy    (resp_rdy),
        .live_cnt    (live_cnt),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int exp_live, input int exp_drop);
        chk({tag, ".live_cnt"}, 80'(live_cnt), 80'(exp_live));
        chk({tag, ".drop_cnt"}, 80'(drop_cnt), 80'(exp_drop));
    endtask

    // One clock of stimulus: sq=squash, rq=req_en, rs=memresp_en,
    // rrdy=resp_rdy, exp_rdy=expected req_rdy this cycle.
    task automatic step(input string tag, input logic sq, input logic rq,
                        input logic rs, input logic rrdy, input logic exp_rdy);
        ent_t ent;
        logic drain_exp;
        logic deliver_exp;
        logic issue_exp;
        logic mrdy_exp;
        @(negedge clk);
        squash      = sq;
        req_en      = rq;
        req_msg     = REQ_W'({$urandom(), $urandom(), $urandom()});
        resp_rdy    = rrdy;
        memresp_en  = rs;
        memresp_msg = RESP_W'({$urandom(), $urandom()});
        drain_exp   = (mem_q.size() > 0) && !mem_q[0].live;
        deliver_exp = 1'b0;
        if (rs && mem_q.size() > 0) begin
            ent         = mem_q.pop_front();
            memresp_msg = ent.msg;
            deliver_exp = ent.live && !sq;
            if (deliver_exp) exp_q.push_back(ent.msg);
        end
        if (sq) begin
            for (int i = 0; i < mem_q.size(); i++) mem_q[i].live = 1'b0;
        end
        issue_exp = rq && exp_rdy;
        mrdy_exp  = sq || drain_exp || rrdy;
        #1;
        chk({tag, ".req_rdy"}, 80'(req_rdy), 80'(exp_rdy));
        chk({tag, ".memreq_en"}, 80'(memreq_en), 80'(issue_exp));
        if (issue_exp) begin
            chk({tag, ".memreq_msg"}, 80'(memreq_msg), 80'(req_msg));
            mem_q.push_back({1'b1, req_msg[RESP_W-1:0] ^ 47'h155AA55AA55A});
        end
        if (rs) chk({tag, ".memresp_rdy"}, 80'(memresp_rdy), 80'(mrdy_exp));
        chk({tag, ".resp_en"}, 80'(resp_en), 80'(deliver_exp));
        if (resp_en === 1'b1 && exp_q.size() > 0)
            chk({tag, ".resp_msg"}, 80'(resp_msg), 80'(exp_q.pop_front()));
        @(posedge clk);
        #1;
        squash     = 1'b0;
        req_en     = 1'b0;
        memresp_en = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        squash      = 1'b0;
        req_msg     = '0;
        req_en      = 1'b1;
        memreq_rdy  = 1'b1;
        memresp_msg = '0;
        memresp_en  = 1'b1;
        resp_rdy    = 1'b1;
        #2;
        chk("rst.req_rdy", 80'(req_rdy), 80'(0));
        chk("rst.memreq_en", 80'(memreq_en), 80'(0));
        chk("rst.memresp_rdy", 80'(memresp_rdy), 80'(0));
        chk("rst.resp_en", 80'(resp_en), 80'(0));
        chk_cnt("rst", 0, 0);
        req_en     = 1'b0;
        memresp_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // T1: three requests, three in-order deliveries.
        step("t1.iss0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_cnt("t1.a", 1, 0);
        step("t1.iss1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step("t1.iss2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_cnt("t1.b", 3, 0);
        step("t1.rsp0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_cnt("t1.c", 2, 0);
        step("t1.rsp1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("t1.rsp2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_cnt("t1.d", 0, 0);

        // T2: fill to four; a returning response frees the slot next cycle only.
        for (int i = 0; i < 4; i++) step("t2.iss", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_cnt("t2.full", 4, 0);
        chk("t2.rdy_full", 80'(req_rdy), 80'(0));
        step("t2.rsp_full", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t2.rdy_next", 80'(req_rdy), 80'(1));
        chk_cnt("t2.a", 3, 0);
        for (int i = 0; i < 3; i++) step("t2.rsp", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_cnt("t2.b", 0, 0);

        // T3: squash three live requests, then a post-squash request survives.
        for (int i = 0; i < 3; i++) step("t3.iss", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step("t3.sq", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cnt("t3.a", 0, 3);
        step("t3.iss_post", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_cnt("t3.b", 1, 3);
        step("t3.drop0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("t3.drop1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("t3.drop2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_cnt("t3.c", 1, 0);
        step("t3.live", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_cnt("t3.d", 0, 0);

        // T4: squash with a response and a request in the same cycle.
        for (int i = 0; i < 2; i++) step("t4.iss", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step("t4.sq", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_cnt("t4.a", 0, 1);
        step("t4.drop", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_cnt("t4.b", 0, 0);

        // T5: second squash during DRAIN; drain with resp_rdy low.
        for (int i = 0; i < 2; i++) step("t5.iss", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step("t5.sq0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cnt("t5.a", 0, 2);
        step("t5.iss1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step("t5.sq1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cnt("t5.b", 0, 3);
        step("t5.drain_iss", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk_cnt("t5.c", 1, 2);
        step("t5.drain", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_cnt("t5.d", 1, 1);

        // T6: asynchronous reset mid-DRAIN, away from any clock edge.
        @(negedge clk);
        memreq_rdy = 1'b1;
        req_en     = 1'b1;
        memresp_en = 1'b1;
        resp_rdy   = 1'b1;
        reset_n    = 1'b0;
        #1;
        chk_cnt("t6.rst", 0, 0);
        chk("t6.req_rdy", 80'(req_rdy), 80'(0));
        chk("t6.memreq_en", 80'(memreq_en), 80'(0));
        chk("t6.memresp_rdy", 80'(memresp_rdy), 80'(0));
        chk("t6.resp_en", 80'(resp_en), 80'(0));
        mem_q.delete();
        exp_q.delete();
        req_en     = 1'b0;
        memresp_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step("t6.iss", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_cnt("t6.a", 1, 0);
        step("t6.rsp", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_cnt("t6.b", 0, 0);
        chk("end.exp_q_empty", 80'(exp_q.size()), 80'(0));
        chk("end.mem_q_empty", 80'(mem_q.size()), 80'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
